// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Single-outstanding instruction fetch stage with stall,
//                redirect/flush and stale-response discard.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'hF000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic [15:0] pc_out,
    output logic [3:0]  opcode
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] instr_q;
    logic [15:0] pc_out_q;
    logic        valid_q;
    logic        req_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            valid_q  <= 1'b0;
            pc_out_q <= 16'h0000;
            req_q    <= 1'b0;
        end else if (redirect) begin
            pc_q    <= redirect_pc;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            // A request still in flight must be drained before issuing the new one.
            if ((state_q == S_FETCH || state_q == S_DISCARD) && !imem_valid) begin
                state_q <= S_DISCARD;
                req_q   <= 1'b0;
            end else begin
                state_q <= S_FETCH;
                req_q   <= 1'b1;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_valid) begin
                        instr_q  <= imem_rdata;
                        valid_q  <= 1'b1;
                        pc_out_q <= pc_q;
                        pc_q     <= pc_q + 16'd1;
                        state_q  <= S_HOLD;
                        req_q    <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                        state_q <= S_FETCH;
                        req_q   <= 1'b1;
                    end
                end
                S_DISCARD: begin
                    if (imem_valid) begin
                        state_q <= S_FETCH;
                        req_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc_out      = pc_out_q;
    assign opcode      = instr_q[15:12];

endmodule
`default_nettype wire
